// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - MIPS load/store opcode[2:0] encodings
//   - exception codes reported on exc_code
//   - FSM state type (also exposed on the debug port)
//   - default data-memory window
//   - op_size(): access size in bytes for an opcode
package mips_mem_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_ALIGN   = 2'b01;
    localparam logic [1:0] EXC_RANGE   = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT = 2'b11;

    localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h7FFF0000;
    localparam logic [31:0] DMEM_LAST_DEFAULT = 32'h7FFFFFFF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Unknown opcodes report size 1 so the range arithmetic never
    // underflows; they are rejected as misaligned anyway.
    function automatic logic [2:0] op_size(input logic [2:0] op);
        case (op)
            OP_H, OP_HU: return 3'd2;
            OP_W:        return 3'd4;
            default:     return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the load/store unit (master) and data memory
// (slave).
//   mem_req   master->slave  access request
//   mem_we    master->slave  1 = write
//   mem_be    master->slave  byte enables, bit i covers bits 8i+7:8i
//   mem_addr  master->slave  word-aligned address
//   mem_wdata master->slave  lane-replicated write data
//   mem_ack   slave->master  access completed
//   mem_rdata slave->master  read word, valid with mem_ack
//
// Handshake: mem_req acts as valid and mem_ack as ready/complete. Once
// mem_req rises, mem_we/mem_be/mem_addr/mem_wdata stay stable until the
// cycle in which mem_ack is sampled high; that cycle completes the access
// and mem_req is low on the following cycle. mem_ack seen while mem_req
// is low is ignored.
interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu_lane_align.sv
// Byte-lane steering for little-endian sub-word accesses. Purely
// combinational.
//   op        opcode[2:0]
//   addr_lo   byte address bits [1:0]
//   wdata     store data in the low-order bits
//   rdata     word read from memory
//   be        byte enables for the access (same for loads and stores)
//   wdata_rep store data replicated across all lanes
//   rdata_ext selected lane(s) of rdata, sign- or zero-extended
module lsu_lane_align
    import mips_mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = 32'h0;
        case (op)
            OP_B, OP_BU: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = (op == OP_B) ? {{24{byte_sel[7]}}, byte_sel}
                                         : {24'h0, byte_sel};
            end
            OP_H, OP_HU: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = (op == OP_H) ? {{16{half_sel[15]}}, half_sel}
                                         : {16'h0, half_sel};
            end
            OP_W: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
            default: begin
                be        = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit. Checks each EX/MEM request against alignment
// and the data-memory window, performs one word-aligned byte-enabled
// access over the mem bus, and returns the extended load result.
//   clk, reset_n           clock, asynchronous active-low reset
//   req_valid/store/op/addr/wdata  request from EX/MEM
//   stall                  pipeline hold while an access is outstanding
//   load_valid, load_data  one-cycle load completion pulse and result
//   exc_valid/code/addr    one-cycle exception pulse, code, faulting address
//   mem                    data-memory bus (master side)
//   dbg_state              current FSM state
module mem_stage_lsu
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEFAULT,
    parameter logic [31:0] DMEM_LAST = DMEM_LAST_DEFAULT,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        exc_valid,
    output logic [1:0]  exc_code,
    output logic [31:0] exc_addr,
    lsu_mem_if.master   mem,
    output state_t      dbg_state
);

    localparam int              CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic          store_q, store_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load_valid_q, load_valid_d;
    logic [31:0]   load_data_q, load_data_d;
    logic          exc_valid_q, exc_valid_d;
    logic [1:0]    exc_code_q, exc_code_d;
    logic [31:0]   exc_addr_q, exc_addr_d;

    // Request check
    logic [2:0]  req_size;
    logic [32:0] req_end;
    logic        align_err;
    logic        range_err;
    logic        req_err;
    logic [1:0]  req_code;
    logic        timed_out;

    // Lane steering from the latched request
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    // Bus outputs
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    lsu_lane_align u_lane (
        .op        (op_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem.mem_rdata),
        .be        (lane_be),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    always_comb begin
        req_size  = op_size(req_op);
        // 33-bit end address so a window ending at 32'hFFFFFFFF still works.
        req_end   = {1'b0, req_addr} + 33'(req_size) - 33'd1;
        case (req_op)
            OP_B, OP_BU: align_err = 1'b0;
            OP_H, OP_HU: align_err = req_addr[0];
            OP_W:        align_err = |req_addr[1:0];
            default:     align_err = 1'b1;
        endcase
        // Unsigned codes only exist for loads; a store using one is
        // reported as misaligned.
        if (req_store && (req_op == OP_BU || req_op == OP_HU)) begin
            align_err = 1'b1;
        end
        range_err = (req_addr < DMEM_BASE) || (req_end > {1'b0, DMEM_LAST});
        req_err   = align_err || range_err;
        req_code  = align_err ? EXC_ALIGN : EXC_RANGE;
        timed_out = (cnt_q == CNT_LAST) && !mem.mem_ack;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && !req_err) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem.mem_ack || timed_out) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        case (state_q)
            ST_IDLE: begin
                stall = req_valid && !req_err;
            end
            ST_ACCESS: begin
                // Release the pipeline in the ack cycle itself so the next
                // request can arrive in the first IDLE cycle.
                stall     = !mem.mem_ack;
                mem_req   = 1'b1;
                mem_we    = store_q;
                mem_be    = lane_be;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wdata = lane_wdata;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // Datapath next values
    always_comb begin
        op_d         = op_q;
        store_d      = store_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        load_valid_d = 1'b0;
        load_data_d  = load_data_q;
        exc_valid_d  = 1'b0;
        exc_code_d   = exc_code_q;
        exc_addr_d   = exc_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        exc_valid_d = 1'b1;
                        exc_code_d  = req_code;
                        exc_addr_d  = req_addr;
                    end else begin
                        op_d    = req_op;
                        store_d = req_store;
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        cnt_d   = '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem.mem_ack) begin
                    if (!store_q) begin
                        load_valid_d = 1'b1;
                        load_data_d  = lane_rdata;
                    end
                end else if (timed_out) begin
                    exc_valid_d = 1'b1;
                    exc_code_d  = EXC_TIMEOUT;
                    exc_addr_d  = addr_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q         <= 3'b000;
            store_q      <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            cnt_q        <= '0;
            load_valid_q <= 1'b0;
            load_data_q  <= 32'h0;
            exc_valid_q  <= 1'b0;
            exc_code_q   <= EXC_NONE;
            exc_addr_q   <= 32'h0;
        end else begin
            op_q         <= op_d;
            store_q      <= store_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
            exc_valid_q  <= exc_valid_d;
            exc_code_q   <= exc_code_d;
            exc_addr_q   <= exc_addr_d;
        end
    end

    assign load_valid    = load_valid_q;
    assign load_data     = load_data_q;
    assign exc_valid     = exc_valid_q;
    assign exc_code      = exc_code_q;
    assign exc_addr      = exc_addr_q;
    assign dbg_state     = state_q;

    assign mem.mem_req   = mem_req;
    assign mem.mem_we    = mem_we;
    assign mem.mem_be    = mem_be;
    assign mem.mem_addr  = mem_addr;
    assign mem.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
    import mips_mem_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        exc_valid;
    logic [1:0]  exc_code;
    logic [31:0] exc_addr;
    state_t      dbg_state;

    lsu_mem_if mif ();

    mem_stage_lsu dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_store  (req_store),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .load_valid (load_valid),
        .load_data  (load_data),
        .exc_valid  (exc_valid),
        .exc_code   (exc_code),
        .exc_addr   (exc_addr),
        .mem        (mif),
        .dbg_state  (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_ldata = 32'h0;

    typedef struct {
        logic        store;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] wrep;
        logic [1:0]  code;
        logic [31:0] ldata;
        int          delay;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Driver: one request through accept, access and completion.
    task automatic run_vec(input vec_t v, input string nm);
        int stall_cycles;
        logic [31:0] exp_ld;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_store = v.store;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(negedge clk);
        check({nm, " stall_accept"}, 32'(stall), 32'(v.code == EXC_NONE));
        check({nm, " mem_req_idle"}, 32'(mif.mem_req), 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (v.code != EXC_NONE) begin
            @(negedge clk);
            check({nm, " exc_valid"}, 32'(exc_valid), 32'h1);
            check({nm, " exc_code"}, 32'(exc_code), 32'(v.code));
            check({nm, " exc_addr"}, exc_addr, v.addr);
            check({nm, " no_mem_req"}, 32'(mif.mem_req), 32'h0);
            check({nm, " stall_err"}, 32'(stall), 32'h0);
            return;
        end
        if (!v.store) exp_q.push_back(v.ldata);
        stall_cycles = 1;
        for (int i = 0; i <= v.delay; i++) begin
            if (i == v.delay) begin
                mif.mem_ack   = 1'b1;
                mif.mem_rdata = v.rdata;
            end
            @(negedge clk);
            if (i == 0) begin
                check({nm, " mem_req"}, 32'(mif.mem_req), 32'h1);
                check({nm, " mem_we"}, 32'(mif.mem_we), 32'(v.store));
                check({nm, " mem_be"}, 32'(mif.mem_be), 32'(v.be));
                check({nm, " mem_addr"}, mif.mem_addr, {v.addr[31:2], 2'b00});
                if (v.store) check({nm, " mem_wdata"}, mif.mem_wdata, v.wrep);
            end
            if (i < v.delay) stall_cycles += int'(stall);
            else check({nm, " stall_ack"}, 32'(stall), 32'h0);
            @(posedge clk); #1;
        end
        mif.mem_ack = 1'b0;
        @(negedge clk);
        check({nm, " stall_cycles"}, 32'(stall_cycles), 32'(v.delay + 1));
        check({nm, " load_valid"}, 32'(load_valid), 32'(!v.store));
        check({nm, " exc_quiet"}, 32'(exc_valid), 32'h0);
        check({nm, " mem_req_done"}, 32'(mif.mem_req), 32'h0);
        if (load_valid) begin
            if (exp_q.size() == 0) begin
                check({nm, " unexpected_load"}, 32'h1, 32'h0);
            end else begin
                exp_ld = exp_q.pop_front();
                check({nm, " load_data"}, load_data, exp_ld);
                last_ldata = exp_ld;
            end
        end else begin
            check({nm, " load_data_hold"}, load_data, last_ldata);
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " stall"}, 32'(stall), 32'h0);
        check({nm, " load_valid"}, 32'(load_valid), 32'h0);
        check({nm, " load_data"}, load_data, 32'h0);
        check({nm, " exc_valid"}, 32'(exc_valid), 32'h0);
        check({nm, " exc_code"}, 32'(exc_code), 32'h0);
        check({nm, " exc_addr"}, exc_addr, 32'h0);
        check({nm, " mem_req"}, 32'(mif.mem_req), 32'h0);
        check({nm, " mem_we"}, 32'(mif.mem_we), 32'h0);
        check({nm, " mem_be"}, 32'(mif.mem_be), 32'h0);
        check({nm, " mem_addr"}, mif.mem_addr, 32'h0);
        check({nm, " mem_wdata"}, mif.mem_wdata, 32'h0);
        check({nm, " state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n       = 1'b0;
        req_valid     = 1'b0;
        req_store     = 1'b0;
        req_op        = 3'b000;
        req_addr      = 32'h0;
        req_wdata     = 32'h0;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 32'h0;

        //          st    op     addr          wdata         rdata         be       wrep          code         ldata         dly
        vecs[0]  = '{1'b1, OP_W,  32'h7FFF0010, 32'hDEADBEEF, 32'h0,        4'b1111, 32'hDEADBEEF, EXC_NONE,    32'h0,        3};
        vecs[1]  = '{1'b1, OP_B,  32'h7FFF0013, 32'h000000A5, 32'h0,        4'b1000, 32'hA5A5A5A5, EXC_NONE,    32'h0,        1};
        vecs[2]  = '{1'b0, OP_B,  32'h7FFF0013, 32'h0,        32'hA5000000, 4'b1000, 32'h0,        EXC_NONE,    32'hFFFFFFA5, 0};
        vecs[3]  = '{1'b0, OP_BU, 32'h7FFF0013, 32'h0,        32'hA5000000, 4'b1000, 32'h0,        EXC_NONE,    32'h000000A5, 2};
        vecs[4]  = '{1'b0, OP_H,  32'h7FFF0002, 32'h0,        32'h80017FFF, 4'b1100, 32'h0,        EXC_NONE,    32'hFFFF8001, 1};
        vecs[5]  = '{1'b0, OP_HU, 32'h7FFF0002, 32'h0,        32'h80017FFF, 4'b1100, 32'h0,        EXC_NONE,    32'h00008001, 0};
        vecs[6]  = '{1'b0, OP_W,  32'h7FFF0006, 32'h0,        32'h0,        4'b0000, 32'h0,        EXC_ALIGN,   32'h0,        0};
        vecs[7]  = '{1'b1, OP_W,  32'h00001000, 32'h12345678, 32'h0,        4'b0000, 32'h0,        EXC_RANGE,   32'h0,        0};
        vecs[8]  = '{1'b1, OP_H,  32'h7FFF0000, 32'h1234BEEF, 32'h0,        4'b0011, 32'hBEEFBEEF, EXC_NONE,    32'h0,        0};
        vecs[9]  = '{1'b0, OP_W,  32'h7FFFFFFC, 32'h0,        32'h13579BDF, 4'b1111, 32'h0,        EXC_NONE,    32'h13579BDF, 1};
        vecs[10] = '{1'b0, OP_H,  32'h7FFFFFFF, 32'h0,        32'h0,        4'b0000, 32'h0,        EXC_ALIGN,   32'h0,        0};
        vecs[11] = '{1'b0, OP_H,  32'h7FFFFFFE, 32'h0,        32'hC0DE1234, 4'b1100, 32'h0,        EXC_NONE,    32'hFFFFC0DE, 0};
        vecs[12] = '{1'b0, OP_W,  32'h7FFEFFFC, 32'h0,        32'h0,        4'b0000, 32'h0,        EXC_RANGE,   32'h0,        0};
        vecs[13] = '{1'b1, OP_B,  32'h7FFF0001, 32'h00000055, 32'h0,        4'b0010, 32'h55555555, EXC_NONE,    32'h0,        2};
        vecs[14] = '{1'b1, OP_BU, 32'h7FFF0001, 32'h00000055, 32'h0,        4'b0000, 32'h0,        EXC_ALIGN,   32'h0,        0};
        vecs[15] = '{1'b0, OP_B,  32'h7FFF0001, 32'h0,        32'h00007F00, 4'b0010, 32'h0,        EXC_NONE,    32'h0000007F, 1};

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Timeout: legal load, memory never acks
        @(posedge clk); #1;
        req_valid = 1'b1; req_store = 1'b0; req_op = OP_W;
        req_addr = 32'h7FFF0020; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!mif.mem_req) break;
            n++;
            @(posedge clk); #1;
        end
        check("timeout req_cycles", 32'(n), 32'd16);
        check("timeout exc_valid", 32'(exc_valid), 32'h1);
        check("timeout exc_code", 32'(exc_code), 32'(EXC_TIMEOUT));
        check("timeout exc_addr", exc_addr, 32'h7FFF0020);
        check("timeout stall", 32'(stall), 32'h0);
        check("timeout load_valid", 32'(load_valid), 32'h0);
        check("timeout load_data", load_data, last_ldata);
        check("timeout state", 32'(dbg_state), 32'(ST_IDLE));
        run_vec(vecs[9], "after_timeout");

        // Reset in the middle of an access
        @(posedge clk); #1;
        req_valid = 1'b1; req_store = 1'b0; req_op = OP_W;
        req_addr = 32'h7FFF0040;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_reset pre mem_req", 32'(mif.mem_req), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        last_ldata = 32'h0;
        exp_q.delete();
        @(posedge clk); #1;
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("late_ack mem_req", 32'(mif.mem_req), 32'h0);
        @(posedge clk); #1;
        mif.mem_ack = 1'b0;
        @(negedge clk);
        check("late_ack load_valid", 32'(load_valid), 32'h0);
        check("late_ack load_data", load_data, 32'h0);
        @(negedge clk);
        check("late_ack load_valid2", 32'(load_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
